sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Two-port arbiter that sequences access to the single SDRAM controller logical interface. It serves the latency-critical SPI flash emulation reader and the low-priority serial user command parser. It replaces the combinational `spi_critical` mux, so a user access already in flight when `spi_critical` rises always completes cleanly. It also owns the controller's refresh-inhibit and the edge conversion of the level `ack`.

## Interface
- `ADDR_W`, 32: address width on both requester ports and downstream.
- `DATA_W`, 16: SDRAM data width.
- `clk`  in  1  system clock (132 MHz).
- `reset`  in  1  asynchronous, active-high.
- `spi_req`  in  1  SPI read request, level, held until `spi_ack`.
- `spi_addr`  in  ADDR_W  SPI read address, stable while `spi_req` is high.
- `spi_critical`  in  1  SPI timing-critical window.
- `spi_refresh_inhibit`  in  1  SPI asks to suppress refresh.
- `spi_ack`  out  1  one-cycle pulse, read data valid.
- `spi_rd_data`  out  DATA_W  read data, held until the next ack.
- `user_req`, `user_we`  in  1  user request level (held until `user_ack`), and write enable.
- `user_addr`  in  ADDR_W  user address.
- `user_wr_data`  in  DATA_W  user write data.
- `user_wr_mask`  in  2  user byte mask.
- `user_ack`  out  1  one-cycle pulse.
- `user_rd_data`  out  DATA_W  user read data.
- `user_idle`  out  1  user may issue a request.
- `sd_enable`, `sd_we`  out  1  controller `acc_i` and `we_i`.
- `sd_addr`  out  ADDR_W  controller address.
- `sd_wr_data`  out  DATA_W  controller write data.
- `sd_wr_mask`  out  2  controller byte mask.
- `sd_refresh_inhibit`  out  1  to the controller.
- `sd_ack_level`  in  1  controller `ack_o` (level).
- `sd_rd_data`  in  DATA_W  controller read data.
- `sd_idle`  in  1  controller idle.

## Operation
- States:
  - IDLE: no access in flight.
  - SPI_BUSY: SPI access in flight.
  - USER_BUSY: user access in flight.
  - RELEASE: waiting for `sd_ack_level` to fall.
- IDLE transitions:
  - `spi_req` → SPI_BUSY. SPI always wins a simultaneous request.
  - `user_req && !spi_critical` → USER_BUSY.
  - `user_req` while `spi_critical` is high is deferred, not dropped.
- On entry to a BUSY state, register downstream address/we/data/mask from the winner.
- SPI grants force `sd_we=0`, `sd_wr_data=16'hDEAD`, `sd_wr_mask=2'b00`.
- BUSY: hold `sd_enable=1` until `sd_ack_level=1`.
  - On that cycle, latch `sd_rd_data` into the winner's `rd_data`.
  - Next cycle: pulse the winner's ack, drop `sd_enable`, go to RELEASE.
- RELEASE → IDLE when `sd_ack_level=0`. This guarantees one `acc` per ack.
- `spi_critical` rising during USER_BUSY: the user access completes normally, and SPI is served next.
- `user_idle = sd_idle && !spi_critical && state==IDLE`, combinational.
- `sd_refresh_inhibit = spi_critical && spi_refresh_inhibit`, combinational.
- A requester deasserting `req` after grant is ignored; the access completes, and its ack is still pulsed.
- Reset (any time):
  - State returns to IDLE.
  - All registered outputs go to 0: `sd_enable`, `sd_we`, `sd_addr`, `sd_wr_data`, `sd_wr_mask`, both acks, both `rd_data`.
  - No ack is issued for an aborted access.

## Timing
- `spi_req` seen in IDLE at cycle N → `sd_enable=1` at N+1.
- `sd_ack_level` first high at cycle M → ack pulse and `sd_enable=0` at M+1.
- Back-to-back grant: earliest at 2 cycles after `sd_ack_level` falls.
- Worst-case SPI wait = one full user access + RELEASE + 1 cycle.

## Configuration
- `SDRAM_ARB_STATS_EN` defined adds three stat outputs, all cleared by reset:
  - `stat_spi_grants` (16 bits, wrapping): count of SPI grants.
  - `stat_user_defers` (16 bits, saturating): counts cycles where `user_req` is held in IDLE but blocked by `spi_critical`.
  - `stat_spi_wait_max` (8 bits, saturating): maximum number of cycles from `spi_req` high to SPI grant.
- `SDRAM_ARB_STATS_EN` undefined: ports and counters are absent, and the behaviour is otherwise identical.

## Structure
- Shared package `sdram_arb_pkg`:
  - state enum (IDLE/SPI_BUSY/USER_BUSY/RELEASE);
  - constant `SPI_FILL_DATA=16'hDEAD`;
  - stat widths.
- One sub-module, `sdram_arb_stats`, contains the counters and is instantiated only under the macro.

## Test plan
- SPI read at addr 0x1234, controller acks after 5 cycles with 0x00A5 → `sd_enable` high for 5 cycles, `spi_ack` pulse with `spi_rd_data=0x00A5`, `sd_we=0`.
- `spi_req` and `user_req` rise on the same cycle → SPI granted first; user granted 2 cycles after `sd_ack_level` falls.
- User write 0xBEEF mask 2'b11 in flight, `spi_critical` rises mid-access → user write completes with `user_ack`, then the SPI read is served; `user_idle=0` throughout the critical window.
- `spi_critical=1`, `spi_refresh_inhibit=1` → `sd_refresh_inhibit=1` the same cycle; with `spi_critical=0` it is 0.
- Reset asserted during SPI_BUSY → `sd_enable=0` immediately, no `spi_ack`, next request granted normally after reset.
- With `SDRAM_ARB_STATS_EN`, a user request held 300 cycles under critical → `stat_user_defers=300`; the SPI wait behind the user access is reflected in `stat_spi_wait_max`.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM two-port arbiter.
// The optional statistics block is enabled with SDRAM_ARB_STATS_EN.
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SPI_BUSY,
      USER_BUSY,
      RELEASE
   } arb_state_t;

   localparam logic [15:0] SPI_FILL_DATA = 16'hDEAD;

   localparam int STAT_GRANT_W = 16;
   localparam int STAT_DEFER_W = 16;
   localparam int STAT_WAIT_W  = 8;

endpackage

// File: rtl/sdram_arb_stats.sv
// Grant, deferral and worst-case SPI wait counters for sdram_arbiter.
// Instantiated only when SDRAM_ARB_STATS_EN is defined.
module sdram_arb_stats
   import sdram_arb_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    spi_req,
   input  logic                    spi_grant,
   input  logic                    user_grant,
   input  logic                    spi_busy,
   input  logic                    release_st,
   input  logic                    user_defer,
   output logic [STAT_GRANT_W-1:0] stat_spi_grants,
   output logic [STAT_DEFER_W-1:0] stat_user_defers,
   output logic [STAT_WAIT_W-1:0]  stat_spi_wait_max
);

   logic                   owner_spi;
   logic                   spi_waiting;
   logic [STAT_WAIT_W-1:0] wait_cnt;
   logic [STAT_WAIT_W-1:0] wait_now;

   // While SPI owns the access (busy or draining its ack) a held req is not waiting.
   assign spi_waiting = spi_req && !spi_busy && !(release_st && owner_spi);
   assign wait_now    = (wait_cnt == '1) ? wait_cnt : wait_cnt + STAT_WAIT_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_spi         <= 1'b0;
         wait_cnt          <= '0;
         stat_spi_grants   <= '0;
         stat_user_defers  <= '0;
         stat_spi_wait_max <= '0;
      end else begin
         if (spi_grant)
            owner_spi <= 1'b1;
         else if (user_grant)
            owner_spi <= 1'b0;

         if (spi_grant)
            stat_spi_grants <= stat_spi_grants + STAT_GRANT_W'(1);

         if (user_defer && stat_user_defers != '1)
            stat_user_defers <= stat_user_defers + STAT_DEFER_W'(1);

         if (spi_grant) begin
            wait_cnt <= '0;
            if (wait_now > stat_spi_wait_max)
               stat_spi_wait_max <= wait_now;
         end else if (spi_waiting) begin
            wait_cnt <= wait_now;
         end else begin
            wait_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Sequences SPI-flash reads and user accesses onto one SDRAM controller port.
// Define SDRAM_ARB_STATS_EN to add the stat_* counter outputs.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              spi_req,
   input  logic [ADDR_W-1:0] spi_addr,
   input  logic              spi_critical,
   input  logic              spi_refresh_inhibit,
   output logic              spi_ack,
   output logic [DATA_W-1:0] spi_rd_data,
   input  logic              user_req,
   input  logic              user_we,
   input  logic [ADDR_W-1:0] user_addr,
   input  logic [DATA_W-1:0] user_wr_data,
   input  logic [1:0]        user_wr_mask,
   output logic              user_ack,
   output logic [DATA_W-1:0] user_rd_data,
   output logic              user_idle,
   output logic              sd_enable,
   output logic              sd_we,
   output logic [ADDR_W-1:0] sd_addr,
   output logic [DATA_W-1:0] sd_wr_data,
   output logic [1:0]        sd_wr_mask,
   output logic              sd_refresh_inhibit,
   input  logic              sd_ack_level,
   input  logic [DATA_W-1:0] sd_rd_data,
   input  logic              sd_idle
`ifdef SDRAM_ARB_STATS_EN
   ,
   output logic [STAT_GRANT_W-1:0] stat_spi_grants,
   output logic [STAT_DEFER_W-1:0] stat_user_defers,
   output logic [STAT_WAIT_W-1:0]  stat_spi_wait_max
`endif
);

   arb_state_t state, next_state;
   logic       spi_grant, user_grant;
   logic       spi_done, user_done;

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // NOTE: next_state defaults to state first, so no branch can infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (spi_req)
               next_state = SPI_BUSY;
            else if (user_req && !spi_critical)
               next_state = USER_BUSY;
         end
         SPI_BUSY, USER_BUSY: begin
            if (sd_ack_level)
               next_state = RELEASE;
         end
         RELEASE: begin
            if (!sd_ack_level)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      spi_grant          = (state == IDLE) && spi_req;
      user_grant         = (state == IDLE) && !spi_req && user_req && !spi_critical;
      spi_done           = (state == SPI_BUSY) && sd_ack_level;
      user_done          = (state == USER_BUSY) && sd_ack_level;
      user_idle          = sd_idle && !spi_critical && (state == IDLE);
      sd_refresh_inhibit = spi_critical && spi_refresh_inhibit;
   end

   // Downstream fields are captured once at grant, so later req/addr changes are ignored.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sd_enable    <= 1'b0;
         sd_we        <= 1'b0;
         sd_addr      <= '0;
         sd_wr_data   <= '0;
         sd_wr_mask   <= 2'b00;
         spi_ack      <= 1'b0;
         user_ack     <= 1'b0;
         spi_rd_data  <= '0;
         user_rd_data <= '0;
      end else begin
         sd_enable <= (next_state == SPI_BUSY) || (next_state == USER_BUSY);
         spi_ack   <= spi_done;
         user_ack  <= user_done;
         if (spi_done)
            spi_rd_data <= sd_rd_data;
         if (user_done)
            user_rd_data <= sd_rd_data;
         if (spi_grant) begin
            sd_addr    <= spi_addr;
            sd_we      <= 1'b0;
            sd_wr_data <= DATA_W'(SPI_FILL_DATA);
            sd_wr_mask <= 2'b00;
         end else if (user_grant) begin
            sd_addr    <= user_addr;
            sd_we      <= user_we;
            sd_wr_data <= user_wr_data;
            sd_wr_mask <= user_wr_mask;
         end
      end
   end

`ifdef SDRAM_ARB_STATS_EN
   sdram_arb_stats u_stats (
      .clk               (clk),
      .reset             (reset),
      .spi_req           (spi_req),
      .spi_grant         (spi_grant),
      .user_grant        (user_grant),
      .spi_busy          (state == SPI_BUSY),
      .release_st        (state == RELEASE),
      .user_defer        ((state == IDLE) && user_req && spi_critical),
      .stat_spi_grants   (stat_spi_grants),
      .stat_user_defers  (stat_user_defers),
      .stat_spi_wait_max (stat_spi_wait_max)
   );
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter with a level-ack SDRAM controller model.
// Stat outputs are checked when SDRAM_ARB_STATS_EN is defined.
module tb_sdram_arbiter;

   typedef struct {
      bit          is_spi;
      logic [31:0] addr;
      bit          we;
      logic [15:0] wdata;
      logic [1:0]  mask;
   } txn_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        spi_req, spi_critical, spi_refresh_inhibit;
   logic [31:0] spi_addr;
   logic        spi_ack;
   logic [15:0] spi_rd_data;
   logic        user_req, user_we;
   logic [31:0] user_addr;
   logic [15:0] user_wr_data;
   logic [1:0]  user_wr_mask;
   logic        user_ack, user_idle;
   logic [15:0] user_rd_data;
   logic        sd_enable, sd_we, sd_refresh_inhibit;
   logic [31:0] sd_addr;
   logic [15:0] sd_wr_data;
   logic [1:0]  sd_wr_mask;
   logic        sd_ack_level;
   logic [15:0] sd_rd_data;
   logic        sd_idle;
`ifdef SDRAM_ARB_STATS_EN
   logic [15:0] stat_spi_grants, stat_user_defers;
   logic [7:0]  stat_spi_wait_max;
`endif

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   ctrl_lat = 5;
   int   ctrl_cnt = 0;
   int   spi_set_cyc = 0;
   int   rise_cyc = 0;
   int   fall_cyc = 0;
   int   exp_grants = 0;
   int   exp_wait_max = 0;
   txn_t grant_q[$];
   txn_t ack_q[$];
   logic en_prev = 1'b0;
   logic ack_prev = 1'b0;

   sdram_arbiter dut (
      .clk                 (clk),
      .reset               (reset),
      .spi_req             (spi_req),
      .spi_addr            (spi_addr),
      .spi_critical        (spi_critical),
      .spi_refresh_inhibit (spi_refresh_inhibit),
      .spi_ack             (spi_ack),
      .spi_rd_data         (spi_rd_data),
      .user_req            (user_req),
      .user_we             (user_we),
      .user_addr           (user_addr),
      .user_wr_data        (user_wr_data),
      .user_wr_mask        (user_wr_mask),
      .user_ack            (user_ack),
      .user_rd_data        (user_rd_data),
      .user_idle           (user_idle),
      .sd_enable           (sd_enable),
      .sd_we               (sd_we),
      .sd_addr             (sd_addr),
      .sd_wr_data          (sd_wr_data),
      .sd_wr_mask          (sd_wr_mask),
      .sd_refresh_inhibit  (sd_refresh_inhibit),
      .sd_ack_level        (sd_ack_level),
      .sd_rd_data          (sd_rd_data),
      .sd_idle             (sd_idle)
`ifdef SDRAM_ARB_STATS_EN
      ,
      .stat_spi_grants     (stat_spi_grants),
      .stat_user_defers    (stat_user_defers),
      .stat_spi_wait_max   (stat_spi_wait_max)
`endif
   );

   always #4 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] exp_rd(input logic [31:0] addr);
      if (addr == 32'h1234) return 16'h00A5;
      return addr[15:0] ^ 16'hC3C3;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Controller model: ack_level rises in the ctrl_lat-th enable cycle, falls after enable drops.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         sd_ack_level <= 1'b0;
         ctrl_cnt     <= 0;
      end else if (sd_enable && !sd_ack_level) begin
         if (ctrl_cnt == ctrl_lat - 2) sd_ack_level <= 1'b1;
         else                          ctrl_cnt <= ctrl_cnt + 1;
      end else if (!sd_enable && sd_ack_level) begin
         sd_ack_level <= 1'b0;
         ctrl_cnt     <= 0;
      end
   end
   assign sd_rd_data = sd_ack_level ? exp_rd(sd_addr) : 16'hFFFF;

   // Monitor: grants are compared against grant_q, acks against ack_q.
   always @(negedge clk) begin
      txn_t t;
      int   w;
      if (!reset) begin
         if (sd_enable && !en_prev) begin
            rise_cyc = cyc;
            if (grant_q.size() == 0) begin
               check("unexpected_grant", {31'b0, sd_enable}, 32'd0);
            end else begin
               t = grant_q.pop_front();
               check("grant_addr",  sd_addr, t.addr);
               check("grant_we",    {31'b0, sd_we}, {31'b0, t.we});
               check("grant_wdata", {16'b0, sd_wr_data}, {16'b0, t.wdata});
               check("grant_mask",  {30'b0, sd_wr_mask}, {30'b0, t.mask});
               if (t.is_spi) begin
                  exp_grants++;
                  w = cyc - spi_set_cyc;
                  if (w > exp_wait_max) exp_wait_max = w;
               end
               ack_q.push_back(t);
            end
         end
         if (!sd_ack_level && ack_prev) fall_cyc = cyc;
         if (spi_ack || user_ack) begin
            if (ack_q.size() == 0) begin
               check("unexpected_ack", {30'b0, spi_ack, user_ack}, 32'd0);
            end else begin
               t = ack_q.pop_front();
               check("ack_port", {30'b0, spi_ack, user_ack}, t.is_spi ? 32'd2 : 32'd1);
               check("ack_enable_low", {31'b0, sd_enable}, 32'd0);
               if (t.is_spi) check("spi_rd_data",  {16'b0, spi_rd_data},  {16'b0, exp_rd(t.addr)});
               else          check("user_rd_data", {16'b0, user_rd_data}, {16'b0, exp_rd(t.addr)});
            end
         end
      end
      en_prev  = reset ? 1'b0 : sd_enable;
      ack_prev = sd_ack_level;
   end

   function automatic logic probe(input int sel);
      case (sel)
         0:       return spi_ack;
         1:       return user_ack;
         default: return sd_enable;
      endcase
   endfunction

   task automatic wait_until(input string tag, input int sel, input int budget);
      for (int i = 0; i < budget && !probe(sel); i++) @(negedge clk);
      check(tag, {31'b0, probe(sel)}, 32'd1);
   endtask

   task automatic spi_start(input logic [31:0] addr);
      txn_t t;
      t.is_spi = 1'b1; t.addr = addr; t.we = 1'b0; t.wdata = 16'hDEAD; t.mask = 2'b00;
      grant_q.push_back(t);
      spi_addr    = addr;
      spi_req     = 1'b1;
      spi_set_cyc = cyc;
   endtask

   task automatic user_start(input bit we, input logic [31:0] addr, input logic [15:0] data,
                             input logic [1:0] mask);
      txn_t t;
      t.is_spi = 1'b0; t.addr = addr; t.we = we; t.wdata = data; t.mask = mask;
      grant_q.push_back(t);
      user_we = we; user_addr = addr; user_wr_data = data; user_wr_mask = mask;
      user_req = 1'b1;
   endtask

`ifdef SDRAM_ARB_STATS_EN
   task automatic check_stats(input string tag, input int defers);
      check({tag, "_grants"},   {16'b0, stat_spi_grants},  exp_grants);
      check({tag, "_defers"},   {16'b0, stat_user_defers}, defers);
      check({tag, "_wait_max"}, {24'b0, stat_spi_wait_max}, exp_wait_max);
   endtask
`endif

   initial begin
      int  en_cnt;
      logic seen;
      reset = 1'b1;
      spi_req = 0; spi_addr = 0; spi_critical = 0; spi_refresh_inhibit = 0;
      user_req = 0; user_we = 0; user_addr = 0; user_wr_data = 0; user_wr_mask = 0;
      sd_idle = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_sd_enable", {31'b0, sd_enable}, 32'd0);
      check("rst_sd_addr",   sd_addr, 32'd0);
      check("rst_sd_wdata",  {16'b0, sd_wr_data}, 32'd0);
      check("rst_acks",      {30'b0, spi_ack, user_ack}, 32'd0);
      check("rst_rd_data",   {spi_rd_data, user_rd_data}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_user_idle", {31'b0, user_idle}, 32'd1);

      // SPI read, 5-cycle controller latency
      ctrl_lat = 5;
      spi_start(32'h1234);
      @(negedge clk);
      check("spi_grant_latency", {31'b0, sd_enable}, 32'd1);
      en_cnt = 0;
      for (int i = 0; i < 40 && !spi_ack; i++) begin
         if (sd_enable) en_cnt++;
         @(negedge clk);
      end
      check("spi_ack_seen", {31'b0, spi_ack}, 32'd1);
      check("spi_enable_cycles", en_cnt, 32'd5);
      spi_req = 1'b0;
      repeat (3) @(negedge clk);
      check("spi_rd_hold", {16'b0, spi_rd_data}, 32'h00A5);

      // Simultaneous requests: SPI first, user two cycles after ack_level falls
      spi_start(32'h0000_0100);
      user_start(1'b0, 32'h0000_0200, 16'h0000, 2'b00);
      wait_until("sim_spi_ack", 0, 40);
      spi_req = 1'b0;
      @(negedge clk);
      wait_until("sim_user_grant", 2, 40);
      #1;
      check("back_to_back_gap", rise_cyc - fall_cyc, 32'd2);
      wait_until("sim_user_ack", 1, 40);
      user_req = 1'b0;
      repeat (3) @(negedge clk);

      // User write in flight when the critical window opens
      ctrl_lat = 8;
      user_start(1'b1, 32'h0000_0040, 16'hBEEF, 2'b11);
      wait_until("wr_grant", 2, 10);
      repeat (2) @(negedge clk);
      spi_critical = 1'b1;
      spi_start(32'h0000_2000);
      for (int i = 0; i < 40 && !user_ack; i++) begin
         check("user_idle_crit_wr", {31'b0, user_idle}, 32'd0);
         @(negedge clk);
      end
      check("wr_user_ack", {31'b0, user_ack}, 32'd1);
      user_req = 1'b0;
      for (int i = 0; i < 40 && !spi_ack; i++) begin
         check("user_idle_crit_spi", {31'b0, user_idle}, 32'd0);
         @(negedge clk);
      end
      check("crit_spi_ack", {31'b0, spi_ack}, 32'd1);
      spi_req = 1'b0;
      @(negedge clk);
      check("user_idle_crit_end", {31'b0, user_idle}, 32'd0);
      spi_critical = 1'b0;
      repeat (4) @(negedge clk);
      check("user_idle_after_crit", {31'b0, user_idle}, 32'd1);

      // Refresh inhibit and user_idle are combinational
      spi_critical = 1'b1; spi_refresh_inhibit = 1'b1; #1;
      check("refresh_inhibit_on", {31'b0, sd_refresh_inhibit}, 32'd1);
      spi_critical = 1'b0; #1;
      check("refresh_inhibit_nocrit", {31'b0, sd_refresh_inhibit}, 32'd0);
      spi_refresh_inhibit = 1'b0;
      sd_idle = 1'b0; #1;
      check("user_idle_sd_busy", {31'b0, user_idle}, 32'd0);
      sd_idle = 1'b1;
      @(negedge clk);

      // User request deferred for 300 cycles by the critical window
      ctrl_lat = 4;
      spi_critical = 1'b1;
      user_start(1'b0, 32'h0000_0300, 16'h0000, 2'b00);
      repeat (300) @(negedge clk);
      check("defer_no_grant", {31'b0, sd_enable}, 32'd0);
      spi_critical = 1'b0;
      wait_until("defer_user_ack", 1, 40);
      user_req = 1'b0;
      repeat (3) @(negedge clk);
`ifdef SDRAM_ARB_STATS_EN
      check_stats("stats_run", 300);
`endif

      // Reset during SPI_BUSY aborts the access without an ack
      ctrl_lat = 10;
      spi_start(32'h0000_0777);
      wait_until("rst_spi_grant", 2, 10);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_enable", {31'b0, sd_enable}, 32'd0);
      check("rst_mid_ack", {31'b0, spi_ack}, 32'd0);
      check("rst_mid_addr", sd_addr, 32'd0);
      grant_q.delete();
      ack_q.delete();
      exp_grants = 0;
      exp_wait_max = 0;
      spi_req = 1'b0;
      @(negedge clk);
`ifdef SDRAM_ARB_STATS_EN
      check_stats("stats_rst", 0);
`endif
      reset = 1'b0;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (spi_ack || user_ack || sd_enable) seen = 1'b1;
      end
      check("rst_no_activity", {31'b0, seen}, 32'd0);

      ctrl_lat = 3;
      spi_start(32'h0000_55AA);
      @(negedge clk);
      check("post_rst_grant", {31'b0, sd_enable}, 32'd1);
      wait_until("post_rst_ack", 0, 40);
      spi_req = 1'b0;
      repeat (3) @(negedge clk);
`ifdef SDRAM_ARB_STATS_EN
      check_stats("stats_post_rst", 0);
`endif
      check("queues_drained", grant_q.size() + ack_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1);
   end

endmodule
